mmio_port_bank: RTL and testbench
=================================

MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

Interface
REQ-001 Parameter N_IN, default 2: number of input channels, range 1..16.
REQ-002 Parameter N_OUT, default 1: number of output channels, range 1..16.
REQ-003 Parameter IW, default 8: input channel width, range 1..32.
REQ-004 Parameter OW, default 16: output channel width, range 1..32.
REQ-005 Parameter FILT, default 4: stability cycles before an input change is accepted, range 1..255.
REQ-006 Parameter BASE, default 32'h0000_0400: bank base address, 256-byte aligned.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 we  in  1  bus write strobe, one cycle per access.
REQ-010 re  in  1  bus read strobe, one cycle per access; qualifies read side effects only.
REQ-011 addr  in  32  byte address.
REQ-012 wdata  in  32  write data.
REQ-013 rdata  out  32  read data, combinational from addr and current state.
REQ-014 hit  out  1  high when addr[31:8]==BASE[31:8].
REQ-015 din  in  N_IN*IW  asynchronous input channels, channel i at [i*IW +: IW].
REQ-016 dout  out  N_OUT*OW  registered output channels, channel j at [j*OW +: OW].
REQ-017 irq  out  1  level interrupt; present only under MMIO_IRQ_EN.

Function
REQ-018 Each din channel SHALL pass a 2-flop synchronizer before any other use.
REQ-019 Per channel, a counter SHALL reset to 0 whenever the synchronized value differs from the previous sample, and increment (saturating at FILT) otherwise.
REQ-020 The filtered value SHALL update to the synchronized value on the cycle the counter reaches FILT, so din-to-filtered latency is 2+FILT cycles for a stable change.
REQ-021 When a filtered value changes, status bit i SHALL set and stay set until cleared.
REQ-022 Word offset 0x00+4*i (i<N_IN) SHALL read the filtered value, zero-extended to 32 bits.
REQ-023 Offset 0x40 SHALL read status[N_IN-1:0]; a write to it SHALL clear each bit whose wdata bit is 1 (W1C).
REQ-024 If a status set and a W1C clear for the same bit occur in the same cycle, the set SHALL win.
REQ-025 A read (re=1) at 0x40 SHALL have no side effect.
REQ-026 Offset 0x80+4*j (j<N_OUT) SHALL read and write output register j; a write SHALL load wdata[OW-1:0], visible on dout the next cycle.
REQ-027 Unmapped offsets and channels beyond N_IN/N_OUT SHALL read 0 and ignore writes.
REQ-028 With hit=0, rdata SHALL be 0 and we SHALL have no effect.
REQ-029 addr[1:0] SHALL be ignored; all accesses are full-word.

Reset
REQ-030 While reset=0: synchronizers, filtered values, counters, status, and output registers SHALL all be 0; dout=0; irq=0.
REQ-031 Reset assertion mid-filter SHALL discard the pending change; after release, a held non-zero input SHALL need the full 2+FILT cycles again.

Configuration
REQ-032 MMIO_IRQ_EN defined: offset 0x44 SHALL be a read/write enable mask ien[N_IN-1:0] (reset 0); irq SHALL be registered |(status & ien), asserting one cycle after the enabling status bit sets.
REQ-033 MMIO_IRQ_EN undefined: no irq port; offset 0x44 SHALL read 0 and ignore writes.

Structure
REQ-034 Register offsets (0x00, 0x40, 0x44, 0x80) and the parameter range limits SHALL live in the shared package mmio_pkg.
REQ-035 The per-channel synchronizer and filter SHALL be a sub-module, in_filter, instantiated N_IN times.

Verification
REQ-036 din ch0 0x00->0x5A held, FILT=4 -> rdata@0x00 reads 0x5A from cycle 6, and status bit0=1.
REQ-037 din ch1 glitched to 0xFF for 3 cycles, FILT=4 -> filtered value stays 0 and status bit1=0.
REQ-038 Write 0x1234 to 0x80 -> dout[15:0]=0x1234 next cycle; a read of 0x84 with N_OUT=1 returns 0.
REQ-039 status=0b11, write 0x1 to 0x40 in the same cycle that ch0 changes again -> status stays 0b11; write 0x2 -> status=0b01.
REQ-040 MMIO_IRQ_EN defined, ien=0x2, ch1 changes -> irq=1 one cycle after status bit1 sets; W1C 0x2 -> irq=0 the next cycle.
REQ-041 Reset pulsed low mid-filter with dout=0x1234 -> dout=0, status=0, and the filtered value re-qualifies after 2+FILT cycles.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port bank: register offsets, parameter
// limits and the offset decoder used by the bank top.
package mmio_pkg;

    // Byte offsets within the 256-byte bank window
    localparam logic [7:0] OFF_IN     = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h40;
    localparam logic [7:0] OFF_IEN    = 8'h44;
    localparam logic [7:0] OFF_OUT    = 8'h80;

    // Legal parameter ranges
    localparam int N_CH_MIN = 1;
    localparam int N_CH_MAX = 16;
    localparam int W_MIN    = 1;
    localparam int W_MAX    = 32;
    localparam int FILT_MIN = 1;
    localparam int FILT_MAX = 255;

    // Filter counter must hold FILT_MAX
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_IN,
        RGN_STATUS,
        RGN_IEN,
        RGN_OUT
    } region_e;

    // Classify a word offset (addr[7:2]); byte lanes are never decoded.
    function automatic region_e decode_region(input logic [5:0] woff);
        region_e r;
        r = RGN_NONE;
        if (woff[5:4] == OFF_IN[7:6])
            r = RGN_IN;
        else if (woff == OFF_STATUS[7:2])
            r = RGN_STATUS;
        else if (woff == OFF_IEN[7:2])
            r = RGN_IEN;
        else if (woff[5:4] == OFF_OUT[7:6])
            r = RGN_OUT;
        return r;
    endfunction

endpackage

// File: rtl/mmio_port_bank_in_filter.sv
// in_filter: one input channel -- 2-flop synchronizer followed by a
// stability filter. The filtered value only follows the synchronized value
// once it has been seen unchanged for FILT consecutive comparisons.
module in_filter
    import mmio_pkg::*;
#(
    parameter int IW   = 8,
    parameter int FILT = 4
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] i_din,
    output logic [IW-1:0] o_filt,
    output logic          o_chg
);

    localparam logic [CNT_W-1:0] FILT_C = CNT_W'(FILT);

    logic [IW-1:0]    r_sync1;
    logic [IW-1:0]    r_sync2;
    logic [IW-1:0]    r_filt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_take;

    // Two-stage synchronizer for the asynchronous channel input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: the sample about to become the synchronized value
    // is compared with the one currently held; any difference restarts it.
    always_comb begin
        w_cnt_next = '0;
        if (r_sync1 == r_sync2)
            w_cnt_next = (r_cnt == FILT_C) ? r_cnt : r_cnt + 1'b1;
        w_take = (w_cnt_next == FILT_C);
        o_chg  = w_take && (r_sync2 != r_filt);
    end

    // Counter and filtered value registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_filt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_take)
                r_filt <= r_sync2;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/mmio_port_bank.sv
// mmio_port_bank: memory-mapped bank of filtered input channels, a sticky
// W1C change-status register and registered output channels.
// Optional feature macro: MMIO_IRQ_EN adds an interrupt-enable register at
// offset 0x44 and a registered level interrupt output irq.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int          N_IN  = 2,
    parameter int          N_OUT = 1,
    parameter int          IW    = 8,
    parameter int          OW    = 16,
    parameter int          FILT  = 4,
    parameter logic [31:0] BASE  = 32'h0000_0400
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  hit,
    input  logic [N_IN*IW-1:0]    din,
    output logic [N_OUT*OW-1:0]   dout
`ifdef MMIO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic [N_IN-1:0][IW-1:0]  w_filt;
    logic [N_IN-1:0]          w_chg;
    logic [N_IN-1:0]          r_status;
    logic [N_IN-1:0]          w_status_clr;
    logic [N_IN-1:0]          w_status_next;
    logic [N_OUT-1:0][OW-1:0] r_dout;
    region_e                  w_region;
    logic [3:0]               w_idx;
    logic                     w_wr;
    logic                     w_unused;

    assign hit      = (addr[31:8] == BASE[31:8]);
    assign w_region = decode_region(addr[7:2]);
    assign w_idx    = addr[5:2];
    assign w_wr     = we & hit;

    // Reads have no side effects and byte lanes are ignored, so these bits
    // are intentionally not decoded.
    assign w_unused = ^{re, addr[1:0], wdata};

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        in_filter #(
            .IW   (IW),
            .FILT (FILT)
        ) u_in_filter (
            .clk    (clk),
            .reset  (reset),
            .i_din  (din[g*IW +: IW]),
            .o_filt (w_filt[g]),
            .o_chg  (w_chg[g])
        );
    end

    // Status next-state: W1C clear, then new changes OR'd in so a set wins
    always_comb begin
        w_status_clr = '0;
        if (w_wr && w_region == RGN_STATUS)
            w_status_clr = wdata[N_IN-1:0];
        w_status_next = (r_status & ~w_status_clr) | w_chg;
    end

    // Sticky change-status register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_status <= '0;
        else
            r_status <= w_status_next;
    end

    // Output channel registers, loaded by bus writes to implemented channels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= '0;
        end else if (w_wr && w_region == RGN_OUT) begin
            for (int j = 0; j < N_OUT; j++)
                if (w_idx == 4'(j))
                    r_dout[j] <= wdata[OW-1:0];
        end
    end

    assign dout = r_dout;

`ifdef MMIO_IRQ_EN
    logic [N_IN-1:0] r_ien;
    logic            r_irq;

    // Interrupt enable mask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ien <= '0;
        else if (w_wr && w_region == RGN_IEN)
            r_ien <= wdata[N_IN-1:0];
    end

    // Registered level interrupt from enabled status bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_irq <= 1'b0;
        else
            r_irq <= |(r_status & r_ien);
    end

    assign irq = r_irq;
`endif

    // Combinational read mux; anything unimplemented reads as zero
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (w_region)
                RGN_IN: begin
                    for (int i = 0; i < N_IN; i++)
                        if (w_idx == 4'(i))
                            rdata = 32'(w_filt[i]);
                end
                RGN_STATUS: rdata = 32'(r_status);
`ifdef MMIO_IRQ_EN
                RGN_IEN:    rdata = 32'(r_ien);
`endif
                RGN_OUT: begin
                    for (int j = 0; j < N_OUT; j++)
                        if (w_idx == 4'(j))
                            rdata = 32'(r_dout[j]);
                end
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// Self-checking bench for mmio_port_bank with a behavioural reference model.
module tb_mmio_port_bank;

    localparam int          N_IN  = 2;
    localparam int          N_OUT = 1;
    localparam int          IW    = 8;
    localparam int          OW    = 16;
    localparam int          FILT  = 4;
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam logic [31:0] IMASK = (IW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << IW) - 1);
    localparam logic [31:0] OMASK = (OW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << OW) - 1);
    localparam logic [31:0] NMASK = (32'd1 << N_IN) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 we, re;
    logic [31:0]          addr, wdata;
    logic [31:0]          rdata;
    logic                 hit;
    logic [N_IN*IW-1:0]   din;
    logic [N_OUT*OW-1:0]  dout;
`ifdef MMIO_IRQ_EN
    logic                 irq;
`endif

    int n_pass, n_total;

    // Reference model state
    int unsigned m_last[N_IN];
    int unsigned m_run[N_IN];
    int unsigned m_filt[N_IN];
    int unsigned m_pend_val[N_IN];
    bit          m_pend[N_IN];
    int unsigned m_status, m_ien;
    int unsigned m_out[N_OUT];
    bit          m_irq;

    mmio_port_bank #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IW(IW), .OW(OW), .FILT(FILT), .BASE(BASE)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(rdata), .hit(hit), .din(din), .dout(dout)
`ifdef MMIO_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_hit(input logic [31:0] a);
        return (a >> 8) == (BASE >> 8);
    endfunction

    function automatic int unsigned ch_val(input int i);
        logic [31:0] v;
        v = 32'(din >> (i * IW));
        return v & IMASK;
    endfunction

    function automatic int unsigned model_read(input logic [31:0] a);
        int unsigned off;
        if (!is_hit(a)) return 0;
        off = a & 32'h0000_00FC;
        if (off < 4 * N_IN) return m_filt[off / 4];
        if (off == 32'h40) return m_status;
`ifdef MMIO_IRQ_EN
        if (off == 32'h44) return m_ien;
`endif
        if (off >= 32'h80 && off < 32'h80 + 4 * N_OUT) return m_out[(off - 32'h80) / 4];
        return 0;
    endfunction

    function automatic logic [N_OUT*OW-1:0] model_dout();
        logic [N_OUT*OW-1:0] e;
        logic [31:0] v;
        e = '0;
        for (int j = 0; j < N_OUT; j++) begin
            v = m_out[j];
            e[j*OW +: OW] = v[OW-1:0];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_IN; i++) begin
            m_last[i] = 0; m_run[i] = 0; m_filt[i] = 0;
            m_pend[i] = 0; m_pend_val[i] = 0;
        end
        for (int j = 0; j < N_OUT; j++) m_out[j] = 0;
        m_status = 0; m_ien = 0; m_irq = 0;
    endtask

    // One rising edge: a value seen on FILT+1 consecutive edges becomes the
    // filtered value one edge later.
    task automatic model_edge();
        int unsigned set_bits, clr, off, d;
        bit irq_n;
        set_bits = 0; clr = 0;
        irq_n = (m_status & m_ien) != 0;
        for (int i = 0; i < N_IN; i++) begin
            if (m_pend[i]) begin
                if (m_pend_val[i] != m_filt[i]) set_bits |= (32'd1 << i);
                m_filt[i] = m_pend_val[i];
                m_pend[i] = 0;
            end
            d = ch_val(i);
            if (d == m_last[i]) begin
                if (m_run[i] < 1000) m_run[i]++;
            end else begin
                m_last[i] = d;
                m_run[i] = 1;
            end
            if (m_run[i] >= FILT + 1) begin
                m_pend[i] = 1;
                m_pend_val[i] = m_last[i];
            end
        end
        if (we && is_hit(addr)) begin
            off = addr & 32'h0000_00FC;
            if (off == 32'h40) clr = wdata;
`ifdef MMIO_IRQ_EN
            if (off == 32'h44) m_ien = wdata & NMASK;
`endif
            if (off >= 32'h80 && off < 32'h80 + 4 * N_OUT)
                m_out[(off - 32'h80) / 4] = wdata & OMASK;
        end
        m_status = ((m_status & ~clr) | set_bits) & NMASK;
        m_irq = irq_n;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        din[i*IW +: IW] = v[IW-1:0];
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] offs[9];
        logic [31:0] a;
        offs = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h80, 32'h84, 32'h88, 32'hC0};
        a = BASE | offs[$urandom_range(8)] | 32'($urandom_range(3));
        if ($urandom_range(9) == 0) a = a ^ 32'h0000_1000;
        return a;
    endfunction

    task automatic test_reset();
        logic [31:0] ra[4];
        ra = '{32'h400, 32'h404, 32'h440, 32'h480};
        repeat (3) tick();
        n_total++;
        if (dout !== '0) $display("FAIL reset_dout: got %h want 0", dout);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            addr = ra[k]; #1;
            n_total++;
            if (rdata !== 32'h0) $display("FAIL reset_rd %h: got %h want 0", ra[k], rdata);
            else n_pass++;
        end
        n_total++;
        if (hit !== 1'b1) $display("FAIL reset_hit: got %b want 1", hit);
        else n_pass++;
        #2 reset = 1'b1;
    endtask

    task automatic test_filter_basic();
        set_ch(0, 32'h5A);
        addr = BASE;
        for (int k = 1; k <= 8; k++) begin
            tick(); #1;
            n_total++;
            if (rdata !== ((k >= FILT + 2) ? 32'h5A : 32'h0))
                $display("FAIL filt_latency k=%0d: got %h want %h", k, rdata,
                         (k >= FILT + 2) ? 32'h5A : 32'h0);
            else n_pass++;
            n_total++;
            if (rdata !== model_read(addr))
                $display("FAIL filt_model k=%0d: got %h want %h", k, rdata, model_read(addr));
            else n_pass++;
        end
        addr = BASE | 32'h40; #1;
        n_total++;
        if (rdata !== 32'h1) $display("FAIL filt_status: got %h want 1", rdata);
        else n_pass++;
    endtask

    task automatic test_glitch();
        set_ch(1, 32'hFF);
        repeat (3) tick();
        set_ch(1, 32'h00);
        addr = BASE | 32'h04;
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            n_total++;
            if (rdata !== 32'h0 || rdata !== model_read(addr))
                $display("FAIL glitch_filt k=%0d: got %h want 0", k, rdata);
            else n_pass++;
        end
        addr = BASE | 32'h40; #1;
        n_total++;
        if (rdata[1] !== 1'b0) $display("FAIL glitch_status: got %h want bit1=0", rdata);
        else n_pass++;
    endtask

    task automatic test_w1c();
        set_ch(1, 32'h33);
        repeat (FILT + 2) tick();
        addr = BASE | 32'h40; #1;
        n_total++;
        if (rdata !== 32'h3) $display("FAIL w1c_pre: got %h want 3", rdata);
        else n_pass++;
        set_ch(0, 32'h77);
        repeat (FILT + 1) tick();
        we = 1'b1; addr = BASE | 32'h40; wdata = 32'h1;
        tick(); #1;
        n_total++;
        if (rdata !== 32'h3 || rdata !== model_read(addr))
            $display("FAIL w1c_set_wins: got %h want 3", rdata);
        else n_pass++;
        addr = BASE; #1;
        n_total++;
        if (rdata !== 32'h77) $display("FAIL w1c_ch0: got %h want 77", rdata);
        else n_pass++;
        we = 1'b1; addr = BASE | 32'h40; wdata = 32'h2;
        tick(); #1;
        n_total++;
        if (rdata !== 32'h1) $display("FAIL w1c_clr1: got %h want 1", rdata);
        else n_pass++;
        re = 1'b1;
        tick(); #1;
        n_total++;
        if (rdata !== 32'h1) $display("FAIL w1c_read_noeffect: got %h want 1", rdata);
        else n_pass++;
        we = 1'b1; wdata = 32'h1;
        tick(); #1;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL w1c_clr0: got %h want 0", rdata);
        else n_pass++;
    endtask

    task automatic test_outputs();
        we = 1'b1; addr = BASE | 32'h80; wdata = 32'h1234;
        tick();
        n_total++;
        if (dout !== 16'h1234) $display("FAIL out_dout: got %h want 1234", dout);
        else n_pass++;
        addr = BASE | 32'h84; #1;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL out_rd84: got %h want 0", rdata);
        else n_pass++;
        addr = BASE | 32'h80; #1;
        n_total++;
        if (rdata !== 32'h1234) $display("FAIL out_rd80: got %h want 1234", rdata);
        else n_pass++;
        we = 1'b1; addr = BASE | 32'h84; wdata = 32'hBEEF;
        tick();
        we = 1'b1; addr = BASE | 32'h04; wdata = 32'hAA;
        tick();
        n_total++;
        if (dout !== 16'h1234) $display("FAIL out_ignored: got %h want 1234", dout);
        else n_pass++;
        we = 1'b1; addr = BASE | 32'h83; wdata = 32'h5555_ABCD;
        tick();
        n_total++;
        if (dout !== 16'hABCD) $display("FAIL out_bytelane: got %h want abcd", dout);
        else n_pass++;
        addr = BASE | 32'hC0; #1;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL out_unmapped: got %h want 0", rdata);
        else n_pass++;
`ifndef MMIO_IRQ_EN
        we = 1'b1; addr = BASE | 32'h44; wdata = 32'hFFFF_FFFF;
        tick(); #1;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL out_ien_absent: got %h want 0", rdata);
        else n_pass++;
`endif
    endtask

    task automatic test_hit();
        logic [31:0] other[2];
        other = '{32'h0000_0580, 32'h0000_1480};
        for (int k = 0; k < 2; k++) begin
            we = 1'b1; addr = other[k]; wdata = 32'hFFFF;
            tick(); #1;
            n_total++;
            if (hit !== 1'b0 || rdata !== 32'h0)
                $display("FAIL miss_%0d: hit=%b rdata=%h want 0/0", k, hit, rdata);
            else n_pass++;
            n_total++;
            if (dout !== 16'hABCD) $display("FAIL miss_wr_%0d: got %h want abcd", k, dout);
            else n_pass++;
        end
        addr = BASE | 32'hFC; #1;
        n_total++;
        if (hit !== 1'b1) $display("FAIL hit_top: got %b want 1", hit);
        else n_pass++;
    endtask

`ifdef MMIO_IRQ_EN
    task automatic test_irq();
        we = 1'b1; addr = BASE | 32'h44; wdata = 32'h2;
        tick(); #1;
        n_total++;
        if (rdata !== 32'h2) $display("FAIL irq_ien_rd: got %h want 2", rdata);
        else n_pass++;
        we = 1'b1; addr = BASE | 32'h40; wdata = 32'h3;
        tick();
        tick();
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq);
        else n_pass++;
        set_ch(1, m_filt[1] ^ 32'h1);
        repeat (FILT + 2) tick();
        n_total++;
        if (irq !== 1'b0 || m_status !== 32'h2)
            $display("FAIL irq_not_yet: irq=%b status=%h want 0/2", irq, m_status);
        else n_pass++;
        tick();
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_assert: got %b want 1", irq);
        else n_pass++;
        we = 1'b1; addr = BASE | 32'h40; wdata = 32'h2;
        tick();
        tick();
        n_total++;
        if (irq !== 1'b0 || irq !== m_irq) $display("FAIL irq_clear: got %b want 0", irq);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] pick[3];
        int r;
        pick = '{32'h00, 32'h5A, 32'hFF};
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_IN; i++)
                if ($urandom_range(7) == 0)
                    set_ch(i, ($urandom_range(3) == 3) ? $urandom : pick[$urandom_range(2)]);
            r = $urandom_range(9);
            if (r < 3) begin
                we = 1'b1; addr = rand_addr(); wdata = $urandom;
            end else if (r == 3) begin
                re = 1'b1; addr = rand_addr();
            end
            tick();
            addr = rand_addr(); #1;
            n_total++;
            if (rdata !== model_read(addr))
                $display("FAIL rand_rd c=%0d a=%h: got %h want %h", c, addr, rdata, model_read(addr));
            else n_pass++;
            n_total++;
            if (dout !== model_dout() || hit !== is_hit(addr))
                $display("FAIL rand_out c=%0d: dout=%h hit=%b want %h/%b", c, dout, hit,
                         model_dout(), is_hit(addr));
            else n_pass++;
`ifdef MMIO_IRQ_EN
            n_total++;
            if (irq !== m_irq) $display("FAIL rand_irq c=%0d: got %b want %b", c, irq, m_irq);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        we = 1'b1; addr = BASE | 32'h80; wdata = 32'h1234;
        tick();
        we = 1'b1; addr = BASE | 32'h40; wdata = 32'h3;
        tick();
        v = (m_filt[0] == 32'hA5) ? 32'h5B : 32'hA5;
        set_ch(0, v);
        set_ch(1, 32'h0);
        repeat (3) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (dout !== '0) $display("FAIL rstmid_dout: got %h want 0", dout);
        else n_pass++;
        addr = BASE | 32'h40; #1;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL rstmid_status: got %h want 0", rdata);
        else n_pass++;
        repeat (2) tick();
        reset = 1'b1;
        addr = BASE;
        for (int k = 1; k <= FILT + 4; k++) begin
            tick(); #1;
            n_total++;
            if (rdata !== ((k >= FILT + 2) ? v : 32'h0) || rdata !== model_read(addr))
                $display("FAIL rstmid_requal k=%0d: got %h want %h", k, rdata,
                         (k >= FILT + 2) ? v : 32'h0);
            else n_pass++;
        end
        addr = BASE | 32'h40; #1;
        n_total++;
        if (rdata !== 32'h1) $display("FAIL rstmid_status_after: got %h want 1", rdata);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; re = 1'b0;
        addr = BASE; wdata = '0; din = '0;
        n_pass = 0; n_total = 0;
        model_reset();
        test_reset();
        test_filter_basic();
        test_glitch();
        test_w1c();
        test_outputs();
        test_hit();
`ifdef MMIO_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
